fetch_ctrl: RTL and testbench

- Instruction-fetch sequencer in front of imem. It owns the PC, drives imem addr/enable, and tracks the one outstanding access.
- imem has a fixed 1-cycle read latency: the address is registered on one edge and data is valid the following cycle. imem's ready output is not used.
- Fetched words go into a 2-entry output buffer. The buffer has a valid/ready handshake to decode.
- Branch/jump redirects squash any in-flight and buffered instructions.

---
 rtl/fetch_ctrl_pkg.sv | 18 +
 rtl/fetch_ctrl_if.sv | 28 ++
 rtl/def_params.v | 8 +
 rtl/fetch_buf.sv | 52 +++++
 rtl/fetch_ctrl.sv | 71 +++++++
 tb/tb_fetch_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Types shared by the fetch sequencer, its buffer and the bus interface.
`include "def_params.v"
package fetch_ctrl_pkg;
  localparam int AW = `ADDR_SIZE + 1;
  localparam int IW = `INSTR_SIZE + 1;

  typedef logic [AW-1:0] addr_t;
  typedef logic [IW-1:0] instr_t;

  typedef struct packed {
    addr_t  pc;
    instr_t instr;
  } fetch_entry_t;

  function automatic addr_t word_align(addr_t a);
    return {a[AW-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_ctrl_if.sv
// imem request/response plus redirect and decode handshake of the fetch unit.
interface fetch_ctrl_if;
  import fetch_ctrl_pkg::*;

  addr_t  imem_addr;
  logic   imem_enable;
  instr_t imem_data;
  logic   redirect;
  addr_t  redirect_pc;
  logic   instr_valid;
  logic   instr_ready;
  instr_t instr;
  addr_t  instr_pc;

  modport master (
    output imem_addr, imem_enable,
    output instr_valid, instr, instr_pc,
    input  imem_data, redirect, redirect_pc,
    input  instr_ready
  );

  modport slave (
    input  imem_addr, imem_enable,
    input  instr_valid, instr, instr_pc,
    output imem_data, redirect, redirect_pc,
    output instr_ready
  );
endinterface

// File: rtl/def_params.v
// Global width and reset macros shared by the fetch front end.
`ifndef DEF_PARAMS_V
`define DEF_PARAMS_V
`define ADDR_SIZE 31
`define INSTR_SIZE 31
`define RESET_PC_DEFAULT 32'h0000_0000
`define INSTR_BYTES 4
`endif

// File: rtl/fetch_buf.sv
// Two-entry {pc, instr} FIFO with synchronous flush; head is register-only.
module fetch_buf
  import fetch_ctrl_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t push_data_i,
  output logic [1:0]   count_o,
  output fetch_entry_t head_o
);
  fetch_entry_t ent_q [DEPTH];
  logic         hd_q, hd_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         tail;
  logic         do_push, do_pop;

  always_comb begin
    do_pop  = pop_i & (cnt_q != 2'd0);
    do_push = push_i & (cnt_q != 2'(DEPTH));
    tail    = hd_q ^ cnt_q[0];
    cnt_d   = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    hd_d    = hd_q ^ do_pop;
    if (flush_i) begin
      cnt_d = 2'd0;
      hd_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 2'd0;
      hd_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      hd_q  <= hd_d;
      if (do_push) begin
        ent_q[tail] <= push_data_i;
      end
    end
  end

  assign count_o = cnt_q;
  assign head_o  = ent_q[hd_q];
endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues to 1-cycle imem, feeds decode buffer.
`include "def_params.v"
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter addr_t RESET_PC  = `RESET_PC_DEFAULT,
  parameter int    BUF_DEPTH = 2
) (
  input logic          clk,
  input logic          reset,
  fetch_ctrl_if.master bus
);
  addr_t        pc_q, pc_d;
  addr_t        ifl_pc_q, ifl_pc_d;
  logic         ifl_q, ifl_d;
  logic [1:0]   count;
  fetch_entry_t head;
  fetch_entry_t fill_ent;
  logic         valid, pop, fill, issue;
  logic [2:0]   occ;

  always_comb begin
    valid    = (count != 2'd0);
    pop      = valid & bus.instr_ready;
    // a redirect kills the response landing in the same cycle
    fill     = ifl_q & ~bus.redirect;
    occ      = {1'b0, count} + {2'b00, ifl_q};
    issue    = ~reset & ~bus.redirect
             & (occ < 3'(BUF_DEPTH) + {2'b00, pop});
    fill_ent = '{pc: ifl_pc_q, instr: bus.imem_data};
    ifl_d    = issue;
    ifl_pc_d = issue ? pc_q : ifl_pc_q;
    pc_d     = pc_q;
    if (bus.redirect) begin
      pc_d = word_align(bus.redirect_pc);
    end else if (issue) begin
      pc_d = pc_q + AW'(`INSTR_BYTES);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= word_align(RESET_PC);
      ifl_q    <= 1'b0;
      ifl_pc_q <= '0;
    end else begin
      pc_q     <= pc_d;
      ifl_q    <= ifl_d;
      ifl_pc_q <= ifl_pc_d;
    end
  end

  fetch_buf #(
    .DEPTH(BUF_DEPTH)
  ) u_buf (
    .clk        (clk),
    .reset      (reset),
    .push_i     (fill),
    .pop_i      (pop),
    .flush_i    (bus.redirect),
    .push_data_i(fill_ent),
    .count_o    (count),
    .head_o     (head)
  );

  assign bus.imem_enable = issue;
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = valid;
  assign bus.instr       = head.instr;
  assign bus.instr_pc    = head.pc;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl against a 1-cycle-latency imem model.
`include "def_params.v"
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  logic  clk = 1'b0;
  logic  reset;
  int    checks = 0;
  int    errors = 0;
  addr_t exp_q[$];

  fetch_ctrl_if bus();

  fetch_ctrl #(
    .RESET_PC (32'h0),
    .BUF_DEPTH(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  always #5 clk = ~clk;

  function automatic instr_t word_of(addr_t a);
    return 32'h1000 + (a >> 2);
  endfunction

  always @(posedge clk) begin
    bus.imem_data <= bus.imem_enable ? word_of(bus.imem_addr) : 32'hDEAD_BEEF;
  end

  task automatic consume(input string name);
    addr_t e;
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      checks++;
      if (bus.instr_valid !== 1'b1) begin
        errors++;
        $display("FAIL %s_gap: instr_valid=%b required 1", name, bus.instr_valid);
      end else if (bus.instr_ready) begin
        e = exp_q.pop_front();
        if (bus.instr_pc !== e || bus.instr !== word_of(e)) begin
          errors++;
          $display("FAIL %s_data: pc=%h instr=%h required pc=%h instr=%h",
                   name, bus.instr_pc, bus.instr, e, word_of(e));
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d left required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    bus.instr_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (bus.instr_valid !== 1'b0 || bus.instr !== '0 ||
        bus.instr_pc !== '0 || bus.imem_enable !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: v=%b i=%h pc=%h en=%b required 0",
               bus.instr_valid, bus.instr, bus.instr_pc, bus.imem_enable);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (bus.imem_enable !== 1'b1 || bus.imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_issue: en=%b addr=%h required 1 0",
               bus.imem_enable, bus.imem_addr);
    end
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(addr_t'(i * 4));
    @(negedge clk);
    #1;
    checks++;
    if (bus.instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_cycle1: valid=%b required 0", bus.instr_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_stream();
    consume("stream");
  endtask

  task automatic test_stall();
    int    left = 0;
    bit    done = 0;
    bit    got = 0;
    addr_t e;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 9; i++) exp_q.push_back(addr_t'(i * 4));
    for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (!done && bus.instr_valid && bus.instr_pc == 32'h8) begin
        left = 5;
        done = 1;
      end
      bus.instr_ready = (left == 0);
      #1;
      if (left > 0) begin
        checks++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h8 ||
            bus.instr !== 32'h1002 || bus.imem_enable !== 1'b0) begin
          errors++;
          $display("FAIL stall_hold: v=%b pc=%h i=%h en=%b required 1 8 1002 0",
                   bus.instr_valid, bus.instr_pc, bus.instr, bus.imem_enable);
        end
        left--;
      end else if (bus.instr_valid) begin
        got = 1;
        e = exp_q.pop_front();
        checks++;
        if (bus.instr_pc !== e || bus.instr !== word_of(e)) begin
          errors++;
          $display("FAIL stall_data: pc=%h i=%h required pc=%h i=%h",
                   bus.instr_pc, bus.instr, e, word_of(e));
        end
      end else if (got) begin
        checks++;
        errors++;
        $display("FAIL stall_gap: instr_valid=0 required 1");
      end
    end
    bus.instr_ready = 1'b1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL stall_timeout: %0d left required 0", exp_q.size());
    end
  endtask

  task automatic redirect_to(input addr_t tgt, input addr_t first, input string name);
    @(negedge clk);
    bus.redirect = 1'b1;
    bus.redirect_pc = tgt;
    #1;
    checks++;
    if (bus.imem_enable !== 1'b0) begin
      errors++;
      $display("FAIL %s_noissue: en=%b required 0", name, bus.imem_enable);
    end
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(first + addr_t'(i * 4));
    @(negedge clk);
    bus.redirect = 1'b0;
    #1;
    checks++;
    if (bus.instr_valid !== 1'b0 || bus.imem_enable !== 1'b1 ||
        bus.imem_addr !== first) begin
      errors++;
      $display("FAIL %s_r1: v=%b en=%b addr=%h required 0 1 %h",
               name, bus.instr_valid, bus.imem_enable, bus.imem_addr, first);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_r2: valid=%b required 0", name, bus.instr_valid);
    end
    @(negedge clk);
    consume(name);
  endtask

  task automatic test_redirect();
    redirect_to(32'h43, 32'h40, "redirect");
  endtask

  task automatic test_wrap();
    redirect_to(32'hFFFF_FFF8, 32'hFFFF_FFF8, "wrap");
  endtask

  task automatic test_redirect_pop();
    addr_t e;
    @(negedge clk);
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h60;
    exp_q.delete();
    exp_q.push_back(32'h60);
    @(negedge clk);
    bus.redirect = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.instr_ready = 1'b0;
      #1;
      checks++;
      if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h60 ||
          bus.imem_enable !== 1'b0) begin
        errors++;
        $display("FAIL rpop_hold: v=%b pc=%h en=%b required 1 60 0",
                 bus.instr_valid, bus.instr_pc, bus.imem_enable);
      end
    end
    @(negedge clk);
    bus.instr_ready = 1'b1;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h80;
    #1;
    e = exp_q.pop_front();
    checks++;
    if (bus.instr_valid !== 1'b1 || bus.instr_pc !== e ||
        bus.instr !== word_of(e)) begin
      errors++;
      $display("FAIL rpop_accept: v=%b pc=%h required 1 %h",
               bus.instr_valid, bus.instr_pc, e);
    end
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h80 + addr_t'(i * 4));
    @(negedge clk);
    bus.redirect = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (bus.instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL rpop_flush: valid=%b required 0", bus.instr_valid);
    end
    @(negedge clk);
    consume("rpop");
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h100;
    @(negedge clk);
    bus.redirect_pc = 32'h200;
    #1;
    checks++;
    if (bus.imem_enable !== 1'b0 || bus.instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second: en=%b v=%b required 0 0",
               bus.imem_enable, bus.instr_valid);
    end
    exp_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back(32'h200 + addr_t'(i * 4));
    @(negedge clk);
    bus.redirect = 1'b0;
    #1;
    checks++;
    if (bus.imem_enable !== 1'b1 || bus.imem_addr !== 32'h200) begin
      errors++;
      $display("FAIL b2b_issue: en=%b addr=%h required 1 200",
               bus.imem_enable, bus.imem_addr);
    end
    @(negedge clk);
    @(negedge clk);
    consume("b2b");
  endtask

  task automatic test_reset_midstream();
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (bus.imem_enable !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_en: en=%b required 0", bus.imem_enable);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.instr_valid !== 1'b0 || bus.instr !== '0 || bus.instr_pc !== '0) begin
      errors++;
      $display("FAIL rst_mid_out: v=%b i=%h pc=%h required 0",
               bus.instr_valid, bus.instr, bus.instr_pc);
    end
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back(addr_t'(i * 4));
    #1;
    checks++;
    if (bus.imem_enable !== 1'b1 || bus.imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid_issue: en=%b addr=%h required 1 0",
               bus.imem_enable, bus.imem_addr);
    end
    @(negedge clk);
    @(negedge clk);
    consume("rst_mid");
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_pop();
    test_back_to_back();
    test_wrap();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
